// File: rtl/spi_txn_scheduler.sv
// Round-robin scheduler sharing one SPI master among four requesters.
// Each accepted request runs one master transfer and returns the received word tagged with its ID.
module spi_txn_scheduler #(
  parameter int unsigned bits_size  = 10,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             req,
  input  logic [4*bits_size-1:0] req_data,
  input  logic [7:0]             req_slave,
  output logic [3:0]             grant,
  output logic                   rsp_valid,
  output logic [1:0]             rsp_id,
  output logic [bits_size-1:0]   rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [bits_size-1:0]   m_data_in,
  output logic [1:0]             m_slave_sel,
  output logic                   m_tx_start,
  input  logic                   m_rx_done,
  input  logic [bits_size-1:0]   m_data_out
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StStart, StWait, StResp, StGap} state_e;

  state_e               state_q, state_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic [1:0]           cur_id_q, cur_id_d;
  logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [3:0]           grant_q, grant_d;
  logic                 tx_start_q, tx_start_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [1:0]           rsp_id_q, rsp_id_d;
  logic [bits_size-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 busy_q, busy_d;
  logic [bits_size-1:0] data_in_q, data_in_d;
  logic [1:0]           slave_sel_q, slave_sel_d;

  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] cand;

  // First requesting index strictly after the last winner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_id    = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_id_d    = cur_id_q;
    tmo_cnt_d   = tmo_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    grant_d     = 4'b0000;
    tx_start_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    data_in_d   = data_in_q;
    slave_sel_d = slave_sel_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d     = StStart;
          data_in_d   = req_data[int'(win_id)*bits_size +: bits_size];
          slave_sel_d = req_slave[int'(win_id)*2 +: 2];
          cur_id_d    = win_id;
          rr_ptr_d    = win_id;
          grant_d     = 4'b0001 << win_id;
          tx_start_d  = 1'b1;
        end
      end
      StStart: begin
        tmo_cnt_d = '0;
        state_d   = StWait;
      end
      StWait: begin
        // A completion arriving on the timeout cycle still counts as success.
        if (m_rx_done) begin
          rsp_data_d  = m_data_out;
          rsp_err_d   = 1'b0;
          rsp_id_d    = cur_id_q;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StResp: begin
        gap_cnt_d = '0;
        state_d   = StGap;
      end
      StGap: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= 2'd3;
      cur_id_q    <= '0;
      tmo_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      grant_q     <= '0;
      tx_start_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      data_in_q   <= '0;
      slave_sel_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_id_q    <= cur_id_d;
      tmo_cnt_q   <= tmo_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      grant_q     <= grant_d;
      tx_start_q  <= tx_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      data_in_q   <= data_in_d;
      slave_sel_q <= slave_sel_d;
    end
  end

  assign grant       = grant_q;
  assign m_tx_start  = tx_start_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign m_data_in   = data_in_q;
  assign m_slave_sel = slave_sel_q;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed bench for spi_txn_scheduler; the bench plays the SPI master's rx side by hand.
module tb_spi_txn_scheduler;

  localparam int BW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [4*BW-1:0] req_data;
  logic [7:0]    req_slave;
  logic [3:0]    grant;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [BW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;
  logic [BW-1:0] m_data_in;
  logic [1:0]    m_slave_sel;
  logic          m_tx_start;
  logic          m_rx_done;
  logic [BW-1:0] m_data_out;

  int checks = 0;
  int failures = 0;

  spi_txn_scheduler #(
    .bits_size (BW),
    .TIMEOUT   (8),
    .GAP_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .req_slave  (req_slave),
    .grant      (grant),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .m_data_in  (m_data_in),
    .m_slave_sel(m_slave_sel),
    .m_tx_start (m_tx_start),
    .m_rx_done  (m_rx_done),
    .m_data_out (m_data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a grant, then answers the transfer after rx_delay WAIT cycles.
  // Returns with the DUT in RESP; g stays 0 if no grant arrived.
  task automatic run_txn(input int rx_delay, input logic [BW-1:0] word,
                         output logic [3:0] g, output logic [BW-1:0] din,
                         output logic [1:0] sel, output logic rv, output logic [1:0] rid,
                         output logic [BW-1:0] rdata, output logic rerr, output int lat);
    g = '0; din = '0; sel = '0; rv = 1'b0; rid = '0; rdata = '0; rerr = 1'b0; lat = 0;
    while (grant == 4'b0000 && lat < 12) begin
      tick();
      lat++;
    end
    if (grant == 4'b0000) return;
    g = grant; din = m_data_in; sel = m_slave_sel;
    tick();
    repeat (rx_delay) tick();
    m_rx_done = 1'b1; m_data_out = word;
    tick();
    m_rx_done = 1'b0;
    rv = rsp_valid; rid = rsp_id; rdata = rsp_data; rerr = rsp_err;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({grant, rsp_valid, rsp_err, busy, m_tx_start} !== 8'h00 || rsp_data !== '0 ||
        m_data_in !== '0 || m_slave_sel !== 2'd0 || rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs got grant=%b rv=%b err=%b busy=%b start=%b din=%h exp all 0",
               grant, rsp_valid, rsp_err, busy, m_tx_start, m_data_in);
    end
  endtask

  task automatic test_single();
    req = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0001 || m_tx_start !== 1'b1) begin
      failures++;
      $display("FAIL single_grant got grant=%b start=%b exp 0001/1", grant, m_tx_start);
    end
    checks++;
    if (m_slave_sel !== 2'd2 || m_data_in !== 10'h2A5) begin
      failures++;
      $display("FAIL single_route got sel=%0d din=%h exp 2/2a5", m_slave_sel, m_data_in);
    end
    req = 4'b0000;
    req_data[BW-1:0] = 10'h3FF;
    tick();
    checks++;
    if (grant !== 4'b0000 || m_tx_start !== 1'b0 || m_data_in !== 10'h2A5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_wait got grant=%b start=%b din=%h busy=%b exp 0000/0/2a5/1",
               grant, m_tx_start, m_data_in, busy);
    end
    tick();
    m_rx_done = 1'b1; m_data_out = 10'h15A;
    tick();
    m_rx_done = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 10'h15A || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp got v=%b id=%0d data=%h err=%b exp 1/0/15a/0",
               rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 10'h15A) begin
      failures++;
      $display("FAIL single_hold got v=%b data=%h exp 0/15a", rsp_valid, rsp_data);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got busy=%b exp 0", busy);
    end
    req_data[BW-1:0] = 10'h2A5;
  endtask

  task automatic test_round_robin();
    logic [3:0] g; logic [BW-1:0] din, rdata; logic [1:0] sel, rid; logic rv, rerr; int lat;
    logic [BW-1:0] dins [4];
    logic [1:0]    sels [4];
    dins[0] = 10'h2A5; dins[1] = 10'h111; dins[2] = 10'h222; dins[3] = 10'h333;
    sels[0] = 2'd2;    sels[1] = 2'd1;    sels[2] = 2'd3;    sels[3] = 2'd0;
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_txn(i, 10'h100 + BW'(i), g, din, sel, rv, rid, rdata, rerr, lat);
      checks++;
      if (g !== (4'b0001 << (i % 4)) || din !== dins[i % 4] || sel !== sels[i % 4]) begin
        failures++;
        $display("FAIL rr_grant_%0d got g=%b din=%h sel=%0d exp g=%b din=%h sel=%0d",
                 i, g, din, sel, 4'b0001 << (i % 4), dins[i % 4], sels[i % 4]);
      end
      checks++;
      if (rv !== 1'b1 || rid !== 2'(i % 4) || rdata !== 10'h100 + BW'(i) || rerr !== 1'b0) begin
        failures++;
        $display("FAIL rr_rsp_%0d got v=%b id=%0d data=%h err=%b exp 1/%0d/%h/0",
                 i, rv, rid, rdata, rerr, i % 4, 10'h100 + BW'(i));
      end
      checks++;
      if (lat !== ((i == 0) ? 1 : 4)) begin
        failures++;
        $display("FAIL rr_latency_%0d got %0d exp %0d", i, lat, (i == 0) ? 1 : 4);
      end
    end
    req = 4'b0100;
    run_txn(1, 10'h0F0, g, din, sel, rv, rid, rdata, rerr, lat);
    checks++;
    if (g !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_pre got g=%b exp 0100", g);
    end
    req = 4'b0011;
    run_txn(1, 10'h0F1, g, din, sel, rv, rid, rdata, rerr, lat);
    checks++;
    if (g !== 4'b0001 || rid !== 2'd0) begin
      failures++;
      $display("FAIL wrap_first got g=%b id=%0d exp 0001/0", g, rid);
    end
    run_txn(1, 10'h0F2, g, din, sel, rv, rid, rdata, rerr, lat);
    checks++;
    if (g !== 4'b0010 || rid !== 2'd1) begin
      failures++;
      $display("FAIL wrap_second got g=%b id=%0d exp 0010/1", g, rid);
    end
    req = 4'b0000;
  endtask

  task automatic test_timeout();
    logic [3:0] g; logic [BW-1:0] din, rdata; logic [1:0] sel, rid; logic rv, rerr; int lat;
    int n = 0;
    m_data_out = 10'h3FF;
    req = 4'b0010;
    while (grant == 4'b0000 && n < 12) begin
      tick();
      n++;
    end
    checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL tmo_grant got g=%b exp 0010", grant);
    end
    req = 4'b0000;
    tick();
    repeat (7) tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL tmo_early got v=%b exp 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0 || rsp_id !== 2'd1) begin
      failures++;
      $display("FAIL tmo_rsp got v=%b err=%b data=%h id=%0d exp 1/1/000/1",
               rsp_valid, rsp_err, rsp_data, rsp_id);
    end
    req = 4'b0100;
    run_txn(2, 10'h0AB, g, din, sel, rv, rid, rdata, rerr, lat);
    req = 4'b0000;
    checks++;
    if (g !== 4'b0100 || rv !== 1'b1 || rerr !== 1'b0 || rdata !== 10'h0AB) begin
      failures++;
      $display("FAIL tmo_after got g=%b v=%b err=%b data=%h exp 0100/1/0/0ab",
               g, rv, rerr, rdata);
    end
  endtask

  task automatic test_race();
    logic [3:0] g; logic [BW-1:0] din, rdata; logic [1:0] sel, rid; logic rv, rerr; int lat;
    req = 4'b1000;
    run_txn(7, 10'h3C3, g, din, sel, rv, rid, rdata, rerr, lat);
    req = 4'b0000;
    checks++;
    if (g !== 4'b1000 || rv !== 1'b1 || rerr !== 1'b0 || rdata !== 10'h3C3 || rid !== 2'd3) begin
      failures++;
      $display("FAIL race got g=%b v=%b err=%b data=%h id=%0d exp 1000/1/0/3c3/3",
               g, rv, rerr, rdata, rid);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] g; logic [BW-1:0] din, rdata; logic [1:0] sel, rid; logic rv, rerr; int lat;
    int n = 0;
    int bad = 0;
    req = 4'b0001;
    while (grant == 4'b0000 && n < 12) begin
      tick();
      n++;
    end
    req = 4'b0000;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_busy got busy=%b exp 1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({grant, rsp_valid, rsp_err, busy, m_tx_start} !== 8'h00 || m_data_in !== '0 ||
        m_slave_sel !== 2'd0 || rsp_data !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs got grant=%b v=%b busy=%b start=%b din=%h data=%h exp 0",
               grant, rsp_valid, busy, m_tx_start, m_data_in, rsp_data);
    end
    m_rx_done = 1'b1; m_data_out = 10'h1E1;
    tick();
    m_rx_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b0 || m_tx_start !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rstmid_quiet got %0d active cycles exp 0", bad);
    end
    req = 4'b1001;
    run_txn(1, 10'h155, g, din, sel, rv, rid, rdata, rerr, lat);
    checks++;
    if (g !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_ptr got g=%b exp 0001", g);
    end
    req = 4'b1000;
    run_txn(3, 10'h2C7, g, din, sel, rv, rid, rdata, rerr, lat);
    req = 4'b0000;
    checks++;
    if (g !== 4'b1000 || rv !== 1'b1 || rid !== 2'd3 || rdata !== 10'h2C7 || rerr !== 1'b0 ||
        din !== 10'h333 || sel !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_after got g=%b v=%b id=%0d data=%h err=%b din=%h sel=%0d",
               g, rv, rid, rdata, rerr, din, sel);
    end
  endtask

  task automatic test_stray_gap();
    int bad = 0;
    tick();
    m_rx_done = 1'b1; m_data_out = 10'h3FF;
    tick();
    m_rx_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0 || rsp_data !== 10'h2C7) begin
      failures++;
      $display("FAIL stray_gap got %0d rsp pulses data=%h exp 0/2c7", bad, rsp_data);
    end
  endtask

  initial begin
    reset      = 1'b1;
    req        = '0;
    req_data   = {10'h333, 10'h222, 10'h111, 10'h2A5};
    req_slave  = {2'd0, 2'd3, 2'd1, 2'd2};
    m_rx_done  = 1'b0;
    m_data_out = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_race();
    test_reset_mid();
    test_stray_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_txn_scheduler.md
Name: spi_txn_scheduler

Overview:
- Round-robin scheduler that shares one 4-slave SPI master (mode/bits_size parameterised, slaves_num=4) among 4 independent requesters.
- Per granted request it:
  - latches the requester's write word and target slave index;
  - drives the master's data_in, slave select and a one-cycle tx_start;
  - waits for the master's rx_done, with a timeout;
  - returns the received word to the requester tagged with its ID.
- Sits between system-side clients and the SPI master's parallel interface.

Parameters:
- bits_size, 10, SPI word width; matches master/slave bits_size.
- TIMEOUT, 255, max cycles in WAIT before aborting; must be ≥ 1; counter width = clog2(TIMEOUT+1).
- GAP_CYCLES, 2, idle cycles after each response before next arbitration; must be ≥ 1; gives slave select time to deassert.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  reset; synchronous, active-high.
- req  in  4  per-requester request level; bit i = requester i.
- req_data  in  4*bits_size  write words; requester i at [i*bits_size +: bits_size].
- req_slave  in  8  target slave index (0..3); requester i at [2i +: 2].
- grant  out  4  one-hot, one-cycle pulse when requester i's request is accepted.
- rsp_valid  out  1  one-cycle pulse, response available.
- rsp_id  out  2  requester index of the response.
- rsp_data  out  bits_size  word received from slave.
- rsp_err  out  1  1 = transaction timed out.
- busy  out  1  high in every state except IDLE.
- m_data_in  out  bits_size  word to master data_in.
- m_slave_sel  out  2  slave index presented to master select logic.
- m_tx_start  out  1  one-cycle start pulse to master.
- m_rx_done  in  1  master receive-complete pulse.
- m_data_out  in  bits_size  master received word; valid when m_rx_done=1.

Behaviour:
- Reset: all outputs 0; state=IDLE; rr_ptr=3, so requester 0 has first priority; timeout and gap counters 0.
- Reset asserted mid-transaction aborts it:
  - no rsp_valid is issued;
  - m_tx_start never re-pulses;
  - the next request after release is arbitrated from rr_ptr=3.
- States: IDLE, START, WAIT, RESP, GAP.
- IDLE:
  - If req≠0, select the first set bit scanning from (rr_ptr+1) mod 4 upward with wrap.
  - Latch that requester's req_data into m_data_in and req_slave into m_slave_sel.
  - Set cur_id and rr_ptr to the winner; go to START.
  - If req=0, stay in IDLE.
- START (exactly 1 cycle):
  - grant[cur_id]=1 and m_tx_start=1.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - m_data_in and m_slave_sel are held stable through WAIT and RESP.
  - If m_rx_done=1: capture m_data_out into rsp_data, set rsp_err=0, go to RESP.
  - Else, if counter = TIMEOUT-1: set rsp_data=0 and rsp_err=1, go to RESP.
  - Else: increment the counter.
  - m_rx_done and timeout in the same cycle: m_rx_done wins, rsp_err=0.
- RESP (exactly 1 cycle): rsp_valid=1, rsp_id=cur_id; then go to GAP.
- rsp_data, rsp_err and rsp_id hold their values until the next RESP.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- m_rx_done outside WAIT is ignored.
- Latency:
  - req seen in IDLE at cycle T → grant and m_tx_start at T+1.
  - m_rx_done at cycle D → rsp_valid at D+1.
  - Earliest next grant = D+1+GAP_CYCLES+2.
- Requester handshake:
  - req is a level signal sampled only in IDLE.
  - The requester keeps req, req_data and req_slave stable until its grant pulse.
  - Keeping req high after grant requests another transaction.
  - req_data changes after grant do not affect the transaction in flight.
- Fairness: a requester that is continuously requesting is granted within 4 transactions.
- req_slave index k maps to master select line k, active-low one-cold, performed in master/mux logic; this block only presents the index.

Test Plan:
- Single request: req=0001, req_data[0]=10'h2A5, req_slave[0]=2; model slave returns 10'h15A → grant=0001 one cycle after req; m_tx_start one pulse; m_slave_sel=2; rsp_valid with rsp_id=0, rsp_data=10'h15A, rsp_err=0.
- Round-robin: req=1111 held continuously → grant order 0,1,2,3,0; each requester granted exactly once per 4 transactions.
- Pointer wrap: after requester 2 is served, req=0011 → requester 0 granted before requester 1.
- Timeout: TIMEOUT=8, m_rx_done never pulses → rsp_valid 8 cycles after WAIT entry with rsp_err=1, rsp_data=0; next request proceeds normally.
- Race: m_rx_done on the same cycle the timeout would fire → rsp_err=0 and rsp_data = m_data_out.
- Reset mid-WAIT: assert reset for 1 cycle while busy=1 → outputs 0 next cycle, no rsp_valid; req=1000 afterwards is granted and completes normally. Separately, a stray m_rx_done during GAP produces no response.
